// File: rtl/mips_muldiv.sv
// Multi-cycle unsigned MULTU/DIVU unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN to make MULTU a single-cycle combinational multiply.
module mips_muldiv (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [3:0]  AluOP,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        HiWe,
    input  logic        LoWe,
    input  logic [31:0] WrData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULTU = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] op_x;
    logic [31:0] op_y;
    logic [63:0] prod;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;

    // prod holds {partial product, remaining multiplier} for MULTU and
    // {partial remainder, dividend/quotient bits} for DIVU.
    always_comb begin
        mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, op_x} : 33'd0);
        mul_next  = {mul_sum, prod[31:1]};
        div_shift = {prod[63:32], prod[31]};
        div_diff  = div_shift - {1'b0, op_y};
        div_next  = div_diff[32] ? {div_shift[31:0], prod[30:0], 1'b0}
                                 : {div_diff[31:0], prod[30:0], 1'b1};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'd0, X} * {32'd0, Y};
`endif

    assign Busy = (state == MUL) || (state == DIV);
    assign Done = (state == DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 5'd0;
            op_x  <= 32'd0;
            op_y  <= 32'd0;
            prod  <= 64'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (HiWe) HI <= WrData;
                    if (LoWe) LO <= WrData;
                    state <= IDLE;
                    if (Start && AluOP == OP_MULTU) begin
                        op_x <= X;
                        op_y <= Y;
                        cnt  <= 5'd0;
`ifdef MULDIV_FAST_MUL_EN
                        HI    <= fast_prod[63:32];
                        LO    <= fast_prod[31:0];
                        state <= DONE;
`else
                        prod  <= {32'd0, Y};
                        state <= MUL;
`endif
                    end else if (Start && AluOP == OP_DIVU) begin
                        op_x <= X;
                        op_y <= Y;
                        cnt  <= 5'd0;
                        if (Y == 32'd0) begin
                            HI    <= X;
                            LO    <= 32'hFFFF_FFFF;
                            state <= DONE;
                        end else begin
                            prod  <= {32'd0, X};
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    if (cnt == 5'd31) begin
                        HI    <= mul_next[63:32];
                        LO    <= mul_next[31:0];
                        cnt   <= 5'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DIV: begin
                    prod <= div_next;
                    if (cnt == 5'd31) begin
                        HI    <= div_next[63:32];
                        LO    <= div_next[31:0];
                        cnt   <= 5'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Randomized self-checking bench for mips_muldiv against an arithmetic reference model.
module tb_mips_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] x;
    logic [31:0] y;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_hi, m_lo;
    logic [31:0] exp_hi, exp_lo;
    logic [31:0] hold_hi, hold_lo;
    int          exp_lat;

    mips_muldiv dut (
        .CLK(clk), .RST(rst), .Start(start), .AluOP(alu_op), .X(x), .Y(y),
        .HiWe(hi_we), .LoWe(lo_we), .WrData(wr_data),
        .Busy(busy), .Done(done), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request (caller is at a falling edge) and predict its outcome.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        start   = 1'b1;
        alu_op  = op;
        x       = a;
        y       = b;
        hold_hi = m_hi;
        hold_lo = m_lo;
        if (op == 4'd3) begin
            p      = 64'(a) * 64'(b);
            exp_hi = p[63:32];
            exp_lo = p[31:0];
`ifdef MULDIV_FAST_MUL_EN
            exp_lat = 1;
`else
            exp_lat = 33;
`endif
        end else if (b == 32'd0) begin
            exp_hi  = a;
            exp_lo  = 32'hFFFF_FFFF;
            exp_lat = 1;
        end else begin
            exp_hi  = a % b;
            exp_lo  = a / b;
            exp_lat = 33;
        end
    endtask

    task automatic track(input int inj_start_at, input int inj_wr_at);
        @(posedge clk);
        for (int k = 1; k <= exp_lat; k++) begin
            @(negedge clk);
            if (k == 1 || k == inj_start_at + 1) start = 1'b0;
            if (k == 1 || k == inj_wr_at + 1) begin hi_we = 1'b0; lo_we = 1'b0; end
            checkOutput("busy", 64'(busy), 64'(k < exp_lat));
            checkOutput("done", 64'(done), 64'(k == exp_lat));
            if (k < exp_lat)
                checkOutput("hilo_hold", {hi, lo}, {hold_hi, hold_lo});
            else
                checkOutput("hilo_result", {hi, lo}, {exp_hi, exp_lo});
            if (k == inj_start_at && k < exp_lat) begin
                start = 1'b1; alu_op = 4'd4; x = 32'h55; y = 32'd3;
            end
            if (k == inj_wr_at && k < exp_lat) begin
                hi_we = 1'b1; wr_data = 32'hDEAD;
            end
        end
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_done", 64'(done), 64'd0);
        checkOutput("idle_hilo", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        logic saw_done;
        logic [3:0] r_op;
        logic [31:0] r_x, r_y;
        rst = 1'b1; start = 1'b0; alu_op = 4'd0; x = 32'd0; y = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        idle_cycle();

        applyStimulus(4'd3, 32'd7, 32'd6);                 track(0, 0); idle_cycle();
        applyStimulus(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF); track(0, 0); idle_cycle();
        applyStimulus(4'd4, 32'd100, 32'd7);               track(0, 0); idle_cycle();
        applyStimulus(4'd4, 32'd5, 32'd0);                 track(0, 0); idle_cycle();

        // Start and HiWe during an iterative MULTU must be ignored.
        applyStimulus(4'd3, 32'd123456, 32'd789);          track(10, 12); idle_cycle();

        @(negedge clk);
        checkOutput("idle_hilo", {hi, lo}, {m_hi, m_lo});
        hi_we = 1'b1; wr_data = 32'h1111_0000;
        @(negedge clk);
        hi_we = 1'b0; m_hi = 32'h1111_0000;
        checkOutput("mthi", {hi, lo}, {m_hi, m_lo});
        lo_we = 1'b1; wr_data = 32'h0000_2222;
        @(negedge clk);
        lo_we = 1'b0; m_lo = 32'h0000_2222;
        checkOutput("mtlo", {hi, lo}, {m_hi, m_lo});

        start = 1'b1; alu_op = 4'd5;
        @(negedge clk);
        start = 1'b0;
        checkOutput("nop_busy", 64'(busy), 64'd0);
        checkOutput("nop_done", 64'(done), 64'd0);
        idle_cycle();

        // Write and request on the same edge: write lands, result overwrites later.
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hCAFE_0001;
        m_hi = 32'hCAFE_0001; m_lo = 32'hCAFE_0001;
        applyStimulus(4'd3, 32'd9, 32'd11);                track(0, 0); idle_cycle();

        applyStimulus(4'd3, 32'h1234, 32'h5678);           track(0, 0);
        applyStimulus(4'd3, 32'hABCD, 32'h10);             track(0, 0); idle_cycle();

        applyStimulus(4'd4, 32'd1000, 32'd3);
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 20) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_hilo", {hi, lo}, 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", 64'(saw_done), 64'd0);
        idle_cycle();

        for (int i = 0; i < 10; i++) begin
            r_op = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'd4;
            r_x  = $urandom;
            case ($urandom_range(0, 3))
                0:       r_y = 32'd0;
                1:       r_y = $urandom_range(1, 1000);
                default: r_y = $urandom;
            endcase
            @(negedge clk);
            applyStimulus(r_op, r_x, r_y);
            track(0, 0);
            idle_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
